// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin sharing of one external 4-bit adder among NREQ requesters.
// Latency: req_ack 1 cycle after accept, res_valid SETTLE+1 cycles after req_ack; one op per SETTLE+2 cycles.
// Backpressure: requesters hold req_valid until req_ack; `ADDER_RR_SCHED_OVF_CNT_EN adds ovf_cnt/ovf_clr.
module adder_rr_sched #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ack,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  input  logic [4:0]        add_s,
  output logic              res_valid,
  output logic [4:0]        res_sum,
  output logic [IDW-1:0]    res_id,
  output logic              busy
`ifdef ADDER_RR_SCHED_OVF_CNT_EN
  ,
  input  logic              ovf_clr,
  output logic [7:0]        ovf_cnt
`endif
);

  // A zero settle time still needs one HOLD cycle; the counter is 4 bits wide.
  localparam int         SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] CNT_LOAD   = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic            vld_q, vld_d;
  logic [4:0]      sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] req_hi;
  logic [IDW-1:0]  pick_id;
  logic [NREQ-1:0] pick_oh;
  logic [3:0]      pick_a;
  logic [3:0]      pick_b;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (IDW'(i) >= ptr_q);
    end
  end

  assign req_hi = req_valid & hi_mask;

  always_comb begin
    pick_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) pick_id = IDW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_hi[i]) pick_id = IDW'(i);
    end
  end

  always_comb begin
    pick_oh = '0;
    pick_a  = '0;
    pick_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == pick_id) begin
        pick_oh[i] = 1'b1;
        pick_a     = req_a[4*i +: 4];
        pick_b     = req_b[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = 1'b0;
    sum_d   = sum_q;
    id_d    = id_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          win_d   = pick_id;
          a_d     = pick_a;
          b_d     = pick_b;
          ack_d   = pick_oh;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        sum_d   = add_s;
        id_d    = win_q;
        vld_d   = 1'b1;
        ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack   = ack_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign res_valid = vld_q;
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign busy      = busy_q;

`ifdef ADDER_RR_SCHED_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  // Clear wins over a same-cycle carry; the count sticks at 255.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = '0;
    end else if ((state_q == CAPTURE) && add_s[4] && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: three instances (SETTLE 1, 2, 3), each with a behavioural adder on add_a/add_b.
`timescale 1ns/1ps
module tb_adder_rr_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  logic [3:0]  s1_vld, s1_ack, s1_add_a, s1_add_b;
  logic [15:0] s1_a, s1_b;
  logic [4:0]  s1_add_s, s1_sum;
  logic [1:0]  s1_id;
  logic        s1_rv, s1_busy;

  logic [3:0]  s2_vld, s2_ack, s2_add_a, s2_add_b;
  logic [15:0] s2_a, s2_b;
  logic [4:0]  s2_add_s, s2_sum;
  logic [1:0]  s2_id;
  logic        s2_rv, s2_busy;

  logic [3:0]  s3_vld, s3_ack, s3_add_a, s3_add_b;
  logic [15:0] s3_a, s3_b;
  logic [4:0]  s3_add_s, s3_sum;
  logic [1:0]  s3_id;
  logic        s3_rv, s3_busy;

  assign s1_add_s = {1'b0, s1_add_a} + {1'b0, s1_add_b};
  assign s2_add_s = {1'b0, s2_add_a} + {1'b0, s2_add_b};
  assign s3_add_s = {1'b0, s3_add_a} + {1'b0, s3_add_b};

`ifdef ADDER_RR_SCHED_OVF_CNT_EN
  logic       s1_clr, s2_clr, s3_clr;
  logic [7:0] s1_ovf, s2_ovf, s3_ovf;
`endif

  adder_rr_sched #(.NREQ(4), .IDW(2), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(s1_vld), .req_a(s1_a), .req_b(s1_b),
    .req_ack(s1_ack), .add_a(s1_add_a), .add_b(s1_add_b), .add_s(s1_add_s),
    .res_valid(s1_rv), .res_sum(s1_sum), .res_id(s1_id), .busy(s1_busy)
`ifdef ADDER_RR_SCHED_OVF_CNT_EN
    , .ovf_clr(s1_clr), .ovf_cnt(s1_ovf)
`endif
  );

  adder_rr_sched #(.NREQ(4), .IDW(2), .SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(s2_vld), .req_a(s2_a), .req_b(s2_b),
    .req_ack(s2_ack), .add_a(s2_add_a), .add_b(s2_add_b), .add_s(s2_add_s),
    .res_valid(s2_rv), .res_sum(s2_sum), .res_id(s2_id), .busy(s2_busy)
`ifdef ADDER_RR_SCHED_OVF_CNT_EN
    , .ovf_clr(s2_clr), .ovf_cnt(s2_ovf)
`endif
  );

  adder_rr_sched #(.NREQ(4), .IDW(2), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(s3_vld), .req_a(s3_a), .req_b(s3_b),
    .req_ack(s3_ack), .add_a(s3_add_a), .add_b(s3_add_b), .add_s(s3_add_s),
    .res_valid(s3_rv), .res_sum(s3_sum), .res_id(s3_id), .busy(s3_busy)
`ifdef ADDER_RR_SCHED_OVF_CNT_EN
    , .ovf_clr(s3_clr), .ovf_cnt(s3_ovf)
`endif
  );

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ack_of(input int u);
    case (u)
      1:       return s1_ack;
      2:       return s2_ack;
      default: return s3_ack;
    endcase
  endfunction

  function automatic logic rv_of(input int u);
    case (u)
      1:       return s1_rv;
      2:       return s2_rv;
      default: return s3_rv;
    endcase
  endfunction

  function automatic logic [4:0] sum_of(input int u);
    case (u)
      1:       return s1_sum;
      2:       return s2_sum;
      default: return s3_sum;
    endcase
  endfunction

  function automatic logic [1:0] id_of(input int u);
    case (u)
      1:       return s1_id;
      2:       return s2_id;
      default: return s3_id;
    endcase
  endfunction

  task automatic wait_ack(input int u, output logic [3:0] ack);
    ack = '0;
    for (int c = 0; c < 20 && ack == 4'd0; c++) begin
      tick();
      ack = ack_of(u);
    end
    if (ack == 4'd0) begin
      n_run++;
      n_fail++;
      $display("FAIL ack_timeout u%0d: got no req_ack within 20 cycles", u);
    end
  endtask

  task automatic wait_res(input int u, output logic [4:0] sum, output logic [1:0] id, output int t);
    logic seen;
    seen = 1'b0;
    sum  = '0;
    id   = '0;
    t    = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (rv_of(u)) begin
        seen = 1'b1;
        sum  = sum_of(u);
        id   = id_of(u);
        t    = cyc;
      end
    end
    if (!seen) begin
      n_run++;
      n_fail++;
      $display("FAIL res_timeout u%0d: got no res_valid within 20 cycles", u);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One isolated request on the SETTLE=1 instance with cycle-exact checks.
  task automatic single_u1(input int id, input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp_sum);
    s1_a[4*id +: 4] = a;
    s1_b[4*id +: 4] = b;
    s1_vld = 4'b0001 << id;
    tick();
    check("vec_ack", 32'(s1_ack), 32'(4'b0001 << id));
    check("vec_busy_acc", 32'(s1_busy), 1);
    check("vec_add_a", 32'(s1_add_a), 32'(a));
    check("vec_add_b", 32'(s1_add_b), 32'(b));
    s1_vld = '0;
    tick();
    check("vec_ack_pulse", 32'(s1_ack), 0);
    check("vec_busy_hold", 32'(s1_busy), 1);
    check("vec_rv_early", 32'(s1_rv), 0);
    tick();
    check("vec_rv", 32'(s1_rv), 1);
    check("vec_sum", 32'(s1_sum), 32'(exp_sum));
    check("vec_id", 32'(s1_id), 32'(id));
    check("vec_busy_done", 32'(s1_busy), 0);
    tick();
    check("vec_rv_pulse", 32'(s1_rv), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] ack;
    logic [4:0] sum;
    logic [1:0] id;
    int         t;
    int         last_t;
    int         rv_cnt;
    logic [4:0] exp4 [4];

    vt[0] = '{0, 4'd9,  4'd8,  5'd17};
    vt[1] = '{1, 4'd15, 4'd15, 5'd30};
    vt[2] = '{2, 4'd0,  4'd0,  5'd0};
    vt[3] = '{3, 4'd7,  4'd9,  5'd16};
    vt[4] = '{1, 4'd15, 4'd1,  5'd16};
    vt[5] = '{2, 4'd3,  4'd4,  5'd7};

    rst_n  = 1'b0;
    s1_vld = '0; s1_a = '0; s1_b = '0;
    s2_vld = '0; s2_a = '0; s2_b = '0;
    s3_vld = '0; s3_a = '0; s3_b = '0;
`ifdef ADDER_RR_SCHED_OVF_CNT_EN
    s1_clr = 1'b0; s2_clr = 1'b0; s3_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_ack", 32'(s1_ack), 0);
    check("rst_add_a", 32'(s1_add_a), 0);
    check("rst_add_b", 32'(s1_add_b), 0);
    check("rst_rv", 32'(s1_rv), 0);
    check("rst_sum", 32'(s1_sum), 0);
    check("rst_id", 32'(s1_id), 0);
    check("rst_busy", 32'(s1_busy), 0);
    rst_n = 1'b1;

    // All four request at once right after reset: served 0,1,2,3.
    s1_a   = {4'd6, 4'd4, 4'd15, 4'd1};
    s1_b   = {4'd5, 4'd4, 4'd15, 4'd2};
    exp4   = '{5'd3, 5'd30, 5'd8, 5'd11};
    s1_vld = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, ack);
      check("all4_ack", 32'(ack), 32'(4'b0001 << k));
      s1_vld[k] = 1'b0;
      wait_res(1, sum, id, t);
      check("all4_sum", 32'(sum), 32'(exp4[k]));
      check("all4_id", 32'(id), 32'(k));
    end

    for (int v = 0; v < 6; v++) begin
      single_u1(vt[v].id, vt[v].a, vt[v].b, vt[v].sum);
    end

    // Fairness: 0 and 2 held high continuously alternate.
    do_reset();
    s1_a   = {4'd0, 4'd2, 4'd0, 4'd1};
    s1_b   = {4'd0, 4'd2, 4'd0, 4'd1};
    s1_vld = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      wait_ack(1, ack);
      check("fair_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd4);
      wait_res(1, sum, id, t);
      check("fair_id", 32'(id), (k % 2 == 0) ? 32'd0 : 32'd2);
      check("fair_sum", 32'(sum), (k % 2 == 0) ? 32'd2 : 32'd4);
      if (k == 7) s1_vld = '0;
    end
    tick();

    // Reset during HOLD on the SETTLE=3 instance.
    s3_a   = {4'd2, 4'd7, 4'd0, 4'd0};
    s3_b   = {4'd3, 4'd7, 4'd0, 4'd0};
    s3_vld = 4'b0100;
    wait_ack(3, ack);
    check("abort_pre_ack", 32'(ack), 4);
    s3_vld = '0;
    wait_res(3, sum, id, t);
    check("abort_pre_sum", 32'(sum), 14);
    check("abort_pre_id", 32'(id), 2);
    s3_vld = 4'b1000;
    wait_ack(3, ack);
    check("abort_ack", 32'(ack), 8);
    s3_vld = '0;
    tick();
    check("abort_in_hold", 32'(s3_busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_ack", 32'(s3_ack), 0);
    check("abort_rst_add_a", 32'(s3_add_a), 0);
    check("abort_rst_add_b", 32'(s3_add_b), 0);
    check("abort_rst_rv", 32'(s3_rv), 0);
    check("abort_rst_sum", 32'(s3_sum), 0);
    check("abort_rst_id", 32'(s3_id), 0);
    check("abort_rst_busy", 32'(s3_busy), 0);
    tick();
    rst_n  = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s3_rv) rv_cnt++;
    end
    check("abort_no_result", 32'(rv_cnt), 0);
    s3_a   = {4'd9, 4'd3, 4'd0, 4'd0};
    s3_b   = {4'd9, 4'd4, 4'd0, 4'd0};
    s3_vld = 4'b1100;
    wait_ack(3, ack);
    check("abort_post_ack", 32'(ack), 4);
    s3_vld = '0;
    wait_res(3, sum, id, t);
    check("abort_post_sum", 32'(sum), 7);
    check("abort_post_id", 32'(id), 2);

    // Exhaustive through requester 3 on the SETTLE=2 instance, back to back.
    last_t       = 0;
    s2_a[15:12]  = 4'd0;
    s2_b[15:12]  = 4'd0;
    s2_vld       = 4'b1000;
    for (int i = 0; i < 256; i++) begin
      wait_ack(2, ack);
      check("exh_ack", 32'(ack), 8);
      s2_vld = '0;
      wait_res(2, sum, id, t);
      check("exh_sum", 32'(sum), 32'(i / 16 + i % 16));
      check("exh_id", 32'(id), 3);
      if (i > 0) check("exh_spacing", 32'(t - last_t), 4);
      last_t = t;
      if (i < 255) begin
        s2_a[15:12] = 4'((i + 1) / 16);
        s2_b[15:12] = 4'((i + 1) % 16);
        s2_vld      = 4'b1000;
      end
    end

`ifdef ADDER_RR_SCHED_OVF_CNT_EN
    tick();
    s1_a[3:0] = 4'd8;
    s1_b[3:0] = 4'd8;
    for (int k = 0; k < 300; k++) begin
      s1_vld = 4'b0001;
      wait_ack(1, ack);
      s1_vld = '0;
      wait_res(1, sum, id, t);
    end
    check("ovf_sat", 32'(s1_ovf), 255);
    s1_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(s1_ovf), 0);
    s1_clr    = 1'b0;
    s1_a[3:0] = 4'd1;
    s1_b[3:0] = 4'd1;
    for (int k = 0; k < 5; k++) begin
      s1_vld = 4'b0001;
      wait_ack(1, ack);
      s1_vld = '0;
      wait_res(1, sum, id, t);
      check("ovf_nocarry_sum", 32'(sum), 2);
    end
    check("ovf_nocarry", 32'(s1_ovf), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one external 4-bit parallel adder (a[3:0] + b[3:0] -> s[4:0]) among NREQ requesters.
- Arbitrates among requesters, accepts one operand pair, and drives it onto the shared adder's inputs.
- Holds the operands for a programmable settle time, then captures the 5-bit sum and returns it tagged with the requester id.
- Sits between the datapath clients and the single shared adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must equal ceil(log2(NREQ)).
- SETTLE, 1, cycles operands are held on the adder before capture (1..15; 0 is treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request; bit i is requester i.
- req_a  input  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  operand B; same packing as req_a.
- req_ack  output  NREQ  one-hot, one-cycle pulse when requester i's operands are accepted.
- add_a  output  4  operand A driven to the shared adder.
- add_b  output  4  operand B driven to the shared adder.
- add_s  input  5  sum from the shared adder (s4 = carry).
- res_valid  output  1  one-cycle pulse; res_sum and res_id are valid in this cycle.
- res_sum  output  5  captured sum.
- res_id  output  IDW  requester that owns res_sum.
- busy  output  1  high from the accept edge through the capture edge.

Behaviour:
- Reset (async, rst_n=0) forces all registered outputs to zero:
  - state=IDLE; req_ack=0, add_a=0, add_b=0, res_valid=0, res_sum=0, res_id=0, busy=0.
  - Round-robin pointer=0; settle counter=0.
- All outputs are registered.
- IDLE:
  - If any req_valid bit is set, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - On that edge: latch the winner's req_a/req_b into add_a/add_b, set req_ack[winner]=1 for exactly one cycle, set busy=1, load the counter with SETTLE-1, go to HOLD.
  - If no bit is set, stay in IDLE.
- HOLD:
  - add_a/add_b stay stable and req_valid is ignored.
  - Counter decrements each cycle; on the edge where the counter is 0, go to CAPTURE.
- CAPTURE:
  - res_sum<=add_s, res_id<=winner, res_valid<=1 for one cycle.
  - pointer<=(winner+1) mod NREQ; busy<=0; go to IDLE.
  - add_a/add_b keep their last values until the next accept.
- Timing:
  - res_valid is asserted SETTLE+1 cycles after the req_ack pulse.
  - Back-to-back throughput: one operation per SETTLE+2 cycles.
- Handshake:
  - A requester keeps req_valid and its operands stable until it sees req_ack, then deasserts in the following cycle.
  - If req_valid is still high in the next IDLE cycle, it is a new request.
  - Dropping req_valid before ack withdraws the request with no side effects.
- Simultaneous requests: the lowest index at or after the pointer wins; all others wait. No requester waits more than NREQ-1 operations.
- Requests arriving while busy are held pending, not lost, provided the requester keeps req_valid high.
- Arithmetic: no internal addition. res_sum is exactly add_s; the carry is in res_sum[4], no saturation.
- Reset mid-operation aborts the operation: no res_valid, pointer back to 0, and the pending operation is never reported.

Optional Feature:
- Macro: ADDER_RR_SCHED_OVF_CNT_EN.
- Defined:
  - Adds output ovf_cnt (8 bits, reset 0).
  - ovf_cnt increments on every CAPTURE edge where add_s[4]=1 and saturates at 255.
  - Adds input ovf_clr (1 bit): synchronous clear, with clear taking priority over increment.
- Not defined: neither port exists and no counter logic is built.

Test Plan:
- Single request, SETTLE=1: req0 with a=9, b=8 -> req_ack=0001 for one cycle; res_valid 2 cycles later with res_sum=17 (5'b10001), res_id=0; busy high throughout.
- All four req_valid set in the same cycle after reset, each dropped after its ack -> acks in order 0,1,2,3; requester 1 with a=15, b=15 returns res_sum=30 and res_id=1.
- Fairness: req0 and req2 held high continuously -> grants alternate 0,2,0,2 for 8 operations; requesters 1 and 3 are never acked.
- rst_n pulsed low during HOLD with SETTLE=3 -> all outputs 0 immediately, no res_valid for the aborted operation; the next request from req2 is acked with pointer restarted at 0.
- Exhaustive via requester 3, driving a behavioural 4-bit adder model on add_a/add_b/add_s: all 256 (a,b) pairs with SETTLE=2 -> every res_sum equals a+b, res_id=3, spacing exactly 4 cycles between res_valid pulses.
- With ADDER_RR_SCHED_OVF_CNT_EN: 300 operations with a=8, b=8 -> ovf_cnt=255; assert ovf_clr -> ovf_cnt=0 on the next cycle; 5 operations with a=1, b=1 -> ovf_cnt stays 0.
